// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and stream framing sizes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes; word/word_valid are presented
// combinationally in the cycle the final byte of a word is accepted.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        fire,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_reg;
  logic [31:0] shift_reg;

  // Each new byte enters at the top, so after four bytes the first one sits in bits [7:0].
  assign word       = {in_byte, shift_reg[31:8]};
  assign word_valid = fire && (idx_reg == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= 2'd0;
      shift_reg <= 32'd0;
    end else if (clear) begin
      idx_reg   <= 2'd0;
      shift_reg <= 32'd0;
    end else if (fire) begin
      idx_reg   <= idx_reg + 2'd1;
      shift_reg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a byte stream (count header + words) onto the IM write port and holds the
// core in reset until the image is in. Define IMEM_LOADER_CHECKSUM_EN for a trailing sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        IM_we,
  output logic [31:0] IM_addr,
  output logic [31:0] IM_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t           state_reg;
  logic             hdr_idx_reg;
  logic [7:0]       hdr_lo_reg;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic [CNT_W-1:0] hdr_n;
  logic [31:0]      next_addr_reg;
  logic [31:0]      im_addr_reg;
  logic [31:0]      im_data_reg;
  logic [31:0]      word;
  logic             im_we_reg;
  logic             cpu_rst_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;
  logic             accept;
  logic             data_fire;
  logic             word_valid;
  logic             restart;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  localparam state_t ST_POST = ST_CHK;
`else
  localparam state_t ST_POST = ST_DONE;
`endif

  assign in_ready  = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
  assign accept    = in_valid && in_ready;
  assign data_fire = accept && (state_reg == ST_DATA);
  assign restart   = start && ((state_reg == ST_DONE) || (state_reg == ST_ERROR));
  assign hdr_n     = CNT_W'({in_byte, hdr_lo_reg});

  assign IM_we   = im_we_reg;
  assign IM_addr = im_addr_reg;
  assign IM_data = im_data_reg;
  assign cpu_rst = cpu_rst_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .fire       (data_fire),
    .in_byte    (in_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_HDR;
      hdr_idx_reg   <= 1'b0;
      hdr_lo_reg    <= 8'd0;
      n_reg         <= '0;
      word_cnt_reg  <= '0;
      next_addr_reg <= BASE_ADDR;
      im_we_reg     <= 1'b0;
      im_addr_reg   <= BASE_ADDR;
      im_data_reg   <= 32'd0;
      cpu_rst_reg   <= 1'b1;
      busy_reg      <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg      <= 8'd0;
`endif
    end else begin
      im_we_reg <= 1'b0;
      if (restart) begin
        state_reg     <= ST_HDR;
        hdr_idx_reg   <= 1'b0;
        word_cnt_reg  <= '0;
        next_addr_reg <= BASE_ADDR;
        im_addr_reg   <= BASE_ADDR;
        cpu_rst_reg   <= 1'b1;
        busy_reg      <= 1'b1;
        done_reg      <= 1'b0;
        err_reg       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_reg      <= 8'd0;
`endif
      end else begin
        case (state_reg)
          ST_HDR: begin
            if (accept) begin
              if (hdr_idx_reg != 1'(HDR_BYTES - 1)) begin
                hdr_lo_reg  <= in_byte;
                hdr_idx_reg <= 1'b1;
              end else begin
                hdr_idx_reg <= 1'b0;
                n_reg       <= hdr_n;
                if (hdr_n == '0)
                  state_reg <= ST_POST;
                else if (hdr_n > CNT_W'(MAX_WORDS))
                  state_reg <= ST_ERROR;
                else
                  state_reg <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_fire)
              csum_reg <= csum_reg + in_byte;
`endif
            if (word_valid) begin
              im_we_reg     <= 1'b1;
              im_data_reg   <= word;
              im_addr_reg   <= next_addr_reg;
              next_addr_reg <= next_addr_reg + 32'd4;
              word_cnt_reg  <= word_cnt_reg + CNT_W'(1);
              if (word_cnt_reg == n_reg - CNT_W'(1))
                state_reg <= ST_POST;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          ST_CHK: begin
            if (accept)
              state_reg <= (in_byte == csum_reg) ? ST_DONE : ST_ERROR;
          end
`endif
          // Status flags follow the state by one cycle so cpu_rst drops after the last write.
          ST_DONE: begin
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            cpu_rst_reg <= 1'b0;
          end
          ST_ERROR: begin
            err_reg  <= 1'b1;
            busy_reg <= 1'b0;
          end
          default: state_reg <= ST_HDR;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time instruction-memory loader that sits directly upstream of the CPU core's instruction-memory write port. Accepts a byte stream from a host link (UART receiver or bench) over a valid/ready handshake and assembles little-endian 32-bit words. Drives the core's IM write port (IM_we/IM_addr/IM_data) and holds the core in reset until the image is fully written.

Parameters:
MAX_WORDS, 256, largest image accepted, in 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of the first word written
CNT_W, 16, width of the word-count header field and internal counters

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; restarts a load from DONE or ERROR
in_valid  input  1  host byte valid
in_byte  input  8  host byte
in_ready  output  1  loader can accept a byte
IM_we  output  1  instruction-memory write enable, one-cycle pulse per word
IM_addr  output  32  instruction-memory byte address
IM_data  output  32  instruction word
cpu_rst  output  1  active-high reset to the core
busy  output  1  load in progress
done  output  1  image loaded, level
err  output  1  load failed, level

Behaviour:
- Reset values: state=HDR, in_ready=1, IM_we=0, IM_addr=BASE_ADDR, IM_data=0, cpu_rst=1, busy=1, done=0, err=0; byte index and word counters cleared.
- Byte accepted when in_valid && in_ready. in_ready=1 only in HDR, DATA, CHK.
- Stream format: 2-byte word count N (CNT_W bits, LSB first), then N words of 4 bytes, LSB first, then (CHECKSUM_EN only) 1 checksum byte.
- HDR: collects 2 bytes. On 2nd byte: N=0 -> DONE (CHK if CHECKSUM_EN); N>MAX_WORDS -> ERROR; else -> DATA.
- DATA: 2-bit byte index; 4th byte of a word accepted at cycle t -> IM_we=1, IM_data=assembled word, IM_addr=BASE_ADDR+4*k during t+1 (k = word index from 0). IM_we high exactly one cycle. Back-to-back bytes every cycle allowed; no stall.
- After word N-1 is written: -> CHK (CHECKSUM_EN) or DONE, entered at t+1.
- DONE: done=1, busy=0, cpu_rst=0 from the cycle after DONE is entered (registered), so the core leaves reset after the last IM_we has completed.
- ERROR: err=1, busy=0, cpu_rst stays 1, in_ready=0; bytes ignored.
- start in DONE or ERROR: next cycle state=HDR, cpu_rst=1, done=0, err=0, busy=1, counters and checksum cleared, IM_addr=BASE_ADDR. start in HDR/DATA/CHK is ignored.
- Asynchronous rst mid-load aborts immediately: no further IM_we; partially loaded IM contents are not cleared.
- Gaps in in_valid at any point are legal; no timeout.
- IM_addr wraps mod 2^32; IM_addr/IM_data hold their last value when IM_we=0.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN: defined -> 8-bit running sum (mod 256) of all data bytes (header excluded); CHK state accepts 1 byte; match -> DONE, mismatch -> ERROR. Words are already written on mismatch, but cpu_rst stays asserted. Undefined -> no CHK state; DONE follows the last word directly.

Decomposition:
- Package imem_loader_pkg: state encoding (HDR, DATA, CHK, DONE, ERROR), header byte count (2), word byte count (4).
- Sub-module imem_byte_packer: 2-bit index plus 32-bit shift register, outputs word and word_valid pulse; clear input used by start/rst.

Test Plan:
- Stream 02 00 | 13 00 00 00 | 93 00 10 00, in_valid continuous -> IM_we pulses with (0x0,0x00000013) and (0x4,0x00100093) on consecutive words; done=1; cpu_rst falls 1 cycle after DONE.
- Same stream with in_valid toggling 1/0 each cycle -> identical writes; in_ready=1 throughout.
- Header 00 00 -> no IM_we; DONE 1 cycle after 2nd byte; cpu_rst=0 thereafter.
- Header 01 01 (N=257, MAX_WORDS=256) -> err=1, in_ready=0, cpu_rst=1; then start pulse -> state HDR, err=0; a subsequent valid 1-word load succeeds.
- rst asserted after 6 data bytes -> outputs return to reset values asynchronously; reload from header writes word 0 at IM_addr=0.
- CHECKSUM_EN: 01 00 | 13 00 00 00 | 13 -> done=1; same stream with checksum 14 -> err=1, cpu_rst=1 after the single IM_we.
